encoder4to2_reg: RTL and testbench
==================================

ENCODER4TO2_REG -- requirements
Module: encoder4to2_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port I, input, 4 bits: request lines to encode.
REQ-004 SHALL have port E, input, 1 bit: encode enable, sampled with I.
REQ-005 SHALL have port in_valid, input, 1 bit: I/E valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept I/E this cycle.
REQ-007 SHALL have port Y, output, 2 bits: encoded index of the granted request line.
REQ-008 SHALL have port V, output, 1 bit: at least one request was granted (E=1 and I!=0).
REQ-009 SHALL have port M, output, 1 bit: more than one I bit was set (E=1).
REQ-010 SHALL have port out_valid, output, 1 bit: Y/V/M hold a valid result.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result this cycle.

Function
REQ-012 SHALL accept an input on a rising edge where in_valid=1 and in_ready=1; SHALL ignore I/E otherwise.
REQ-013 SHALL compute {Y,V,M} combinationally from accepted I/E and store it in a 2-entry FIFO, oldest first.
REQ-014 SHALL grant, with E=1, the highest-priority set bit of I; default priority is fixed, I[3] highest, I[0] lowest.
REQ-015 SHALL produce Y=0, V=0, M=0 when E=0 or I=0.
REQ-016 SHALL set M=1 iff E=1 and popcount(I)>=2.
REQ-017 SHALL give 1-cycle latency: an input accepted on edge k appears with out_valid=1 after edge k when the FIFO was empty.
REQ-018 SHALL drive out_valid=1 iff FIFO count>=1 and present the head entry on Y/V/M.
REQ-019 SHALL pop the head on an edge where out_valid=1 and out_ready=1.
REQ-020 SHALL drive in_ready=1 iff count<2, as a function of registered count only.
REQ-021 SHALL, on simultaneous push and pop at count=1, keep count=1 and present the new entry.
REQ-022 SHALL hold Y/V/M stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive Y/V/M=0 when count=0.

Reset
REQ-024 SHALL, while rst=1, force count=0, out_valid=0, Y=0, V=0, M=0, in_ready=0, RR pointer=3, regardless of clk.
REQ-025 SHALL drive in_ready=1 from the first clk edge after rst deasserts.
REQ-026 SHALL discard all buffered entries when rst asserts mid-operation.

Configuration
REQ-027 SHALL compile round-robin priority only when macro ENCODER_RR_EN is defined.
REQ-028 With ENCODER_RR_EN, SHALL search I starting at pointer p, descending, wrapping 0->3; on each accept with V=1 and grant g, p <= (g-1) mod 4; p unchanged when V=0.
REQ-029 Without ENCODER_RR_EN, SHALL use fixed priority per REQ-014 and SHALL contain no pointer register.

Structure
REQ-030 SHALL place in package encoder_pkg: entry typedef {Y[1:0],V,M}, FIFO_DEPTH=2, RR_PTR_RESET=2'd3.
REQ-031 SHALL implement the buffer as sub-module enc_fifo2 (2-entry, entry-typed, count-based ready/valid).

Verification
REQ-032 Fixed priority: accept I=4'b0110, E=1, out_ready=1 -> next cycle Y=2, V=1, M=1, out_valid=1.
REQ-033 Enable/zero: accept I=4'b1000,E=0 then I=0,E=1 -> two results Y=0,V=0,M=0.
REQ-034 Backpressure: out_ready=0, push 3 inputs back-to-back -> 2 accepted, in_ready=0 after 2nd edge, 3rd held; out_ready=1 -> results in order, 3rd accepted.
REQ-035 Simultaneous: count=1, push I=4'b0001 and pop same edge -> count stays 1, Y=0, V=1.
REQ-036 Async reset: count=2, pulse rst between edges -> out_valid=0, Y/V/M=0 immediately; in_ready=1 after first edge post-release.
REQ-037 ENCODER_RR_EN: accept I=4'b1111 four times -> Y sequence 3,2,1,0, then 3; each M=1.

Source files
------------

// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder_pkg
// Description : Shared types and constants for the registered 4-to-2
//               priority encoder: result entry layout, FIFO depth, the
//               round-robin pointer reset value and small encode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

  // One encoded result: granted index, grant flag, multiple-request flag.
  typedef struct packed {
    logic [1:0] y;
    logic       v;
    logic       m;
  } enc_entry_t;

  localparam int         FIFO_DEPTH   = 2;
  localparam logic [1:0] RR_PTR_RESET = 2'd3;

  // Number of set request lines.
  function automatic logic [2:0] count_ones(input logic [3:0] bits);
    logic [2:0] n;
    n = 3'd0;
    for (int b = 0; b < 4; b++) begin
      n = n + {2'b00, bits[b]};
    end
    return n;
  endfunction

  // Fixed priority: scanning upward, the last set bit seen is the highest.
  function automatic logic [1:0] fixed_grant(input logic [3:0] req);
    logic [1:0] g;
    g = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (req[b]) begin
        g = 2'(b);
      end
    end
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/encoder4to2_reg_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : enc_fifo2
// Description : Two-entry result buffer with count-based ready/valid.
//               Entries leave oldest first; the head is zeroed on the output
//               whenever the buffer is empty.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               push_i, din_i     - write request and entry to store
//               pop_i             - consumer ready (pops when valid)
//               in_ready_o        - space available (registered state only)
//               out_valid_o       - at least one entry held
//               dout_o            - head entry (zero when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module enc_fifo2
  import encoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  enc_entry_t din_i,
  input  logic       pop_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output enc_entry_t dout_o
);

  localparam logic [1:0] CNT_FULL = 2'(FIFO_DEPTH);

  logic [1:0] count_q, count_d;
  enc_entry_t head_q, head_d;
  enc_entry_t tail_q, tail_d;
  // Held low by reset so the block refuses input until the first edge
  // after reset release.
  logic       live_q;

  logic w_push;
  logic w_pop;

  assign in_ready_o  = live_q && (count_q < CNT_FULL);
  assign out_valid_o = (count_q != 2'd0);
  assign w_push      = push_i && in_ready_o;
  assign w_pop       = pop_i && out_valid_o;
  assign dout_o      = out_valid_o ? head_q : '0;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({w_push, w_pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = din_i;
        end else begin
          tail_d = din_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        tail_d  = '0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Push needs count<2 and pop needs count>=1, so count is 1 here:
        // the new entry replaces the departing head.
        head_d = din_i;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      live_q  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/encoder4to2_reg.sv
`default_nettype none
// ============================================================================
// Module      : encoder4to2_reg
// Description : Registered 4-to-2 priority encoder with ready/valid on both
//               sides and a two-entry result buffer (1-cycle latency).
//               Default priority is fixed (I[3] highest). Defining the macro
//               ENCODER_RR_EN compiles a round-robin grant with a rotating
//               search pointer instead.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               I, E, in_valid     - request lines, enable, input valid
//               in_ready           - input accepted this cycle when high
//               Y, V, M            - granted index, grant, multiple request
//               out_valid          - Y/V/M hold a result
//               out_ready          - consumer takes the result
// Revision    : 1.0 - initial release
// ============================================================================
module encoder4to2_reg
  import encoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] I,
  input  logic       E,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] Y,
  output logic       V,
  output logic       M,
  output logic       out_valid,
  input  logic       out_ready
);

  logic       w_accept;
  logic [1:0] w_grant;
  enc_entry_t w_entry;
  enc_entry_t w_head;

  assign w_accept = in_valid && in_ready;

`ifdef ENCODER_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic       w_rr_hit;

  // Search downward from the pointer, wrapping 0 -> 3; first hit wins.
  always_comb begin
    w_rr_hit = 1'b0;
    w_grant  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!w_rr_hit && I[ptr_q - 2'(k)]) begin
        w_rr_hit = 1'b1;
        w_grant  = ptr_q - 2'(k);
      end
    end
  end

  // After a grant g the next search starts just below g, so g becomes the
  // lowest priority for the following request.
  always_comb begin
    ptr_d = ptr_q;
    if (w_accept && w_entry.v) begin
      ptr_d = w_entry.y - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= RR_PTR_RESET;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign w_grant = fixed_grant(I);
`endif

  always_comb begin
    w_entry = '0;
    if (E && (I != 4'd0)) begin
      w_entry.y = w_grant;
      w_entry.v = 1'b1;
    end
    w_entry.m = E && (count_ones(I) >= 3'd2);
  end

  enc_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid),
    .din_i       (w_entry),
    .pop_i       (out_ready),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .dout_o      (w_head)
  );

  assign Y = w_head.y;
  assign V = w_head.v;
  assign M = w_head.m;

endmodule
`default_nettype wire

// File: tb/tb_encoder4to2_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder4to2_reg
// Description : Self-checking bench for encoder4to2_reg: reset state, a
//               vector table, backpressure / simultaneous push-pop / async
//               reset sequences and randomized traffic against a queue model.
//               Round-robin expectations are used when ENCODER_RR_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder4to2_reg;

  logic       clk;
  logic       rst;
  logic [3:0] I;
  logic       E;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] Y;
  logic       V;
  logic       M;
  logic       out_valid;
  logic       out_ready;

  int checks;
  int failures;

  // Model: queue of 4-bit results {y[1:0], v, m}, oldest at index 0.
  logic [3:0] mq[$];
`ifdef ENCODER_RR_EN
  int mptr;
`endif

  typedef struct packed {
    logic [3:0] i;
    logic       e;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[12];

  encoder4to2_reg dut (
    .clk       (clk),
    .rst       (rst),
    .I         (I),
    .E         (E),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .V         (V),
    .M         (M),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Encode from the rules: highest set bit (or first set bit searching down
  // from the pointer), V when enabled with any request, M on >=2 requests.
  function automatic logic [3:0] enc_model(input logic [3:0] req, input logic en);
    int g;
    g = -1;
`ifdef ENCODER_RR_EN
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (mptr - k + 4) % 4;
      if (g < 0 && req[c]) g = c;
    end
`else
    for (int c = 3; c >= 0; c--) begin
      if (g < 0 && req[c]) g = c;
    end
`endif
    if (!en || g < 0) return 4'b0000;
`ifdef ENCODER_RR_EN
    mptr = (g + 3) % 4;
`endif
    return {2'(g), 1'b1, ($countones(req) >= 2)};
  endfunction

  function automatic logic [5:0] observed();
    return {in_ready, out_valid, Y, V, M};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {rdy,vld,Y,V,M}=%b expected %b", name, act, exp);
    end
  endtask

  // Model update for one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic acc;
    logic pop;
    acc = in_valid && (mq.size() < 2);
    pop = out_ready && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(enc_model(I, E));
  endtask

  function automatic logic [5:0] model_expect();
    logic [3:0] head;
    head = (mq.size() > 0) ? mq[0] : 4'b0000;
    return {(mq.size() < 2), (mq.size() > 0), head};
  endfunction

  initial begin
    logic [3:0] exp;
    logic [1:0] rr_y[5];
    checks   = 0;
    failures = 0;

    tbl[0]  = '{4'b0110, 1'b1, 4'b1011};
    tbl[1]  = '{4'b1000, 1'b0, 4'b0000};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000};
    tbl[3]  = '{4'b0001, 1'b1, 4'b0010};
    tbl[4]  = '{4'b0010, 1'b1, 4'b0110};
    tbl[5]  = '{4'b0100, 1'b1, 4'b1010};
    tbl[6]  = '{4'b1000, 1'b1, 4'b1110};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1111};
    tbl[8]  = '{4'b0011, 1'b1, 4'b0111};
    tbl[9]  = '{4'b1001, 1'b1, 4'b1111};
    tbl[10] = '{4'b0101, 1'b0, 4'b0000};
    tbl[11] = '{4'b1100, 1'b1, 4'b1111};

    rst = 1'b1; I = 4'd0; E = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef ENCODER_RR_EN
    mptr = 3;
`endif

    // ---------------- reset state ----------------
    #1;
    check("reset_async", observed(), 6'b000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held", observed(), 6'b000000);
    rst = 1'b0;
    #1;
    check("release_no_edge", observed(), 6'b000000);
    @(posedge clk);
    #1;
    check("first_edge_ready", observed(), 6'b100000);

`ifdef ENCODER_RR_EN
    // ---------------- round-robin rotation ----------------
    rr_y[0] = 2'd3; rr_y[1] = 2'd2; rr_y[2] = 2'd1; rr_y[3] = 2'd0; rr_y[4] = 2'd3;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      in_valid = 1'b1; I = 4'b1111; E = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      void'(enc_model(I, E));
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("rr_%0d", n), observed(), {2'b11, rr_y[n], 2'b11});
    end
`else
    rr_y[0] = 2'd0;
    if (rr_y[0] != 2'd0) $display("rr table unused");
`endif

    // ---------------- vector table ----------------
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      in_valid = 1'b1; I = tbl[n].i; E = tbl[n].e; out_ready = 1'b1;
      @(posedge clk);
      exp = enc_model(I, E);
`ifndef ENCODER_RR_EN
      exp = tbl[n].exp;
`endif
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("table_%0d", n), observed(), {2'b11, exp});
    end
    @(negedge clk);
    check("table_drained", observed(), 6'b100000);

    // ---------------- backpressure ----------------
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; I = 4'b0100; E = 1'b1;
    @(posedge clk);
    void'(enc_model(I, E));
    @(negedge clk);
    check("bp_first", observed(), 6'b111010);
    I = 4'b0001;
    @(posedge clk);
    void'(enc_model(I, E));
    @(negedge clk);
    check("bp_full", observed(), 6'b011010);
    I = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    check("bp_held_stable", observed(), 6'b011010);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_pop_a", observed(), 6'b110010);
    @(posedge clk);
    void'(enc_model(I, E));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_third", observed(), 6'b111110);
    @(posedge clk);
    @(negedge clk);
    check("bp_empty", observed(), 6'b100000);

    // ---------------- simultaneous push and pop at count 1 ----------------
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; I = 4'b0010; E = 1'b1;
    @(posedge clk);
    void'(enc_model(I, E));
    @(negedge clk);
    check("sim_one", observed(), 6'b110110);
    I = 4'b0001; out_ready = 1'b1;
    @(posedge clk);
    void'(enc_model(I, E));
    @(negedge clk);
    in_valid = 1'b0;
    check("sim_replace", observed(), 6'b110010);
    @(posedge clk);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      check($sformatf("rand_%0d", n), observed(), model_expect());
      in_valid  = ($urandom_range(0, 3) != 0);
      I         = 4'($urandom_range(0, 15));
      E         = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    check("rand_drained", observed(), model_expect());

    // ---------------- async reset mid-operation ----------------
    in_valid = 1'b1; I = 4'b0100; E = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    I = 4'b0001;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_full", observed(), 6'b011010);
    #1 rst = 1'b1;
    #1;
    check("ar_immediate", observed(), 6'b000000);
    mq.delete();
`ifdef ENCODER_RR_EN
    mptr = 3;
`endif
    #1 rst = 1'b0;
    #1;
    check("ar_released", observed(), 6'b000000);
    @(posedge clk);
    #1;
    check("ar_first_edge", observed(), 6'b100000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
